// File: rtl/cu_data_write_packer.sv
// cu_data_write_packer
// Coalesces per-vertex 32-bit float results into 128-byte cacheline write
// commands with per-byte enables, tagged with the edge-data-write control ID.
// One open line buffer collects beats. A single-entry output register holds
// the command presented to the arbiter until it is accepted.
module cu_data_write_packer #(
  parameter int CACHELINE_SIZE = 128,
  parameter int DATA_SIZE_WRITE = 4,
  parameter int ELEM_NUM = CACHELINE_SIZE / DATA_SIZE_WRITE,
  parameter int CMD_ID_BITS = 8,
  parameter logic [CMD_ID_BITS-1:0] CMD_ID = 8'h0B
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enabled,
  input  logic [0:63]                   base_address,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  input  logic [31:0]                   data_in_index,
  input  logic [31:0]                   data_in_value,
  input  logic                          flush,
  output logic                          flush_done,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [0:63]                   cmd_address,
  output logic [0:CACHELINE_SIZE*8-1]   cmd_data,
  output logic [CACHELINE_SIZE-1:0]     cmd_byte_enable,
  output logic [5:0]                    cmd_elem_count,
  output logic [CMD_ID_BITS-1:0]        cmd_id
);

  localparam int LINE_BITS = CACHELINE_SIZE * 8;
  localparam int ELEM_BITS = DATA_SIZE_WRITE * 8;
  localparam logic [5:0] FULL_COUNT = 6'(ELEM_NUM);
  // Clears the 7-bit byte offset inside a 128-byte line.
  localparam logic [0:63] LINE_MASK = 64'hFFFF_FFFF_FFFF_FF80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_OUT   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Expands a per-slot valid vector into per-byte enables.
  function automatic logic [CACHELINE_SIZE-1:0] byte_enables(input logic [ELEM_NUM-1:0] valid);
    logic [CACHELINE_SIZE-1:0] be;
    be = {CACHELINE_SIZE{1'b0}};
    for (int k = 0; k < ELEM_NUM; k++) begin
      be[DATA_SIZE_WRITE*k +: DATA_SIZE_WRITE] = {DATA_SIZE_WRITE{valid[k]}};
    end
    return be;
  endfunction

  // Registered state
  state_t                    state;
  logic [0:LINE_BITS-1]      buf_data;
  logic [ELEM_NUM-1:0]       buf_valid;
  logic [5:0]                buf_count;
  logic [0:63]               open_line;

  // Decode / handshake
  logic [0:63]               beat_addr;
  logic [0:63]               beat_line;
  logic [4:0]                slot;
  logic                      in_flush;
  logic                      out_free;
  logic                      accept;
  logic                      buf_empty;
  logic                      line_match;
  logic                      start_fresh;
  logic                      eject_old;

  // Buffer contents after merging this cycle's beat
  logic [0:LINE_BITS-1]      m_data;
  logic [ELEM_NUM-1:0]       m_valid;
  logic [5:0]                m_count;
  logic [0:63]               m_line;
  logic                      line_full;
  logic                      eject_flush;

  // Next-state values
  state_t                    n_state;
  logic [0:LINE_BITS-1]      n_buf_data;
  logic [ELEM_NUM-1:0]       n_buf_valid;
  logic [5:0]                n_buf_count;
  logic [0:63]               n_open_line;
  logic                      n_out_valid;
  logic [0:63]               n_out_address;
  logic [0:LINE_BITS-1]      n_out_data;
  logic [CACHELINE_SIZE-1:0] n_out_be;
  logic [5:0]                n_out_count;
  logic                      n_flush_done;
  logic                      stay_flush;

  assign cmd_id = CMD_ID;

  // Decode the beat address and qualify the input handshake.
  always_comb begin
    beat_addr     = base_address + {30'd0, data_in_index, 2'b00};
    beat_line     = beat_addr & LINE_MASK;
    slot          = beat_addr[57:61];
    in_flush      = (state == ST_FLUSH);
    out_free      = !cmd_valid || cmd_ready;
    data_in_ready = enabled && out_free && !in_flush;
    accept        = data_in_valid && data_in_ready;
    buf_empty     = (buf_valid == {ELEM_NUM{1'b0}});
    line_match    = (beat_line == open_line);
    start_fresh   = accept && (buf_empty || !line_match);
    eject_old     = accept && !buf_empty && !line_match;
  end

  // Merge an accepted beat into the open buffer, or into a fresh one when
  // the buffer is empty or the beat belongs to another line.
  always_comb begin
    if (start_fresh) begin
      m_data  = {LINE_BITS{1'b0}};
      m_valid = {ELEM_NUM{1'b0}};
      m_count = 6'd0;
      m_line  = beat_line;
    end else begin
      m_data  = buf_data;
      m_valid = buf_valid;
      m_count = buf_count;
      m_line  = open_line;
    end
    if (accept) begin
      m_data[{slot, 5'b00000} +: ELEM_BITS] = data_in_value;
      m_count = m_valid[slot] ? m_count : (m_count + 6'd1);
      m_valid[slot] = 1'b1;
    end else begin
      // No beat this cycle: the merged view is the buffer itself.
    end
    line_full   = (m_count == FULL_COUNT);
    eject_flush = in_flush && !buf_empty && out_free;
  end

  // Next state of the buffer, output register, flush handshake and FSM.
  always_comb begin
    n_buf_data  = m_data;
    n_open_line = m_line;
    if (line_full || eject_flush) begin
      n_buf_valid = {ELEM_NUM{1'b0}};
      n_buf_count = 6'd0;
    end else begin
      n_buf_valid = m_valid;
      n_buf_count = m_count;
    end

    n_out_valid   = cmd_valid;
    n_out_address = cmd_address;
    n_out_data    = cmd_data;
    n_out_be      = cmd_byte_enable;
    n_out_count   = cmd_elem_count;
    if (eject_old) begin
      // Line change: the old line leaves in the same cycle the new beat lands.
      n_out_valid   = 1'b1;
      n_out_address = open_line;
      n_out_data    = buf_data;
      n_out_be      = byte_enables(buf_valid);
      n_out_count   = buf_count;
    end else if (line_full || eject_flush) begin
      n_out_valid   = 1'b1;
      n_out_address = m_line;
      n_out_data    = m_data;
      n_out_be      = byte_enables(m_valid);
      n_out_count   = m_count;
    end else if (cmd_valid && cmd_ready) begin
      n_out_valid = 1'b0;
    end else begin
      // Command held stable until the arbiter accepts it.
      n_out_valid = cmd_valid;
    end

    n_flush_done = 1'b0;
    if (in_flush) begin
      // Done once the buffer is drained and the last command has left.
      if (buf_empty && out_free) begin
        n_flush_done = 1'b1;
        stay_flush   = 1'b0;
      end else begin
        stay_flush   = 1'b1;
      end
    end else if (flush) begin
      // A beat accepted alongside the flush is already part of n_buf_*.
      if ((n_buf_valid == {ELEM_NUM{1'b0}}) && !n_out_valid) begin
        n_flush_done = 1'b1;
        stay_flush   = 1'b0;
      end else begin
        stay_flush   = 1'b1;
      end
    end else begin
      stay_flush = 1'b0;
    end

    if (stay_flush) begin
      n_state = ST_FLUSH;
    end else if (n_out_valid) begin
      n_state = ST_OUT;
    end else if (n_buf_valid != {ELEM_NUM{1'b0}}) begin
      n_state = ST_FILL;
    end else begin
      n_state = ST_IDLE;
    end
  end

  // State, buffer and output registers; reset discards everything at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      buf_data        <= {LINE_BITS{1'b0}};
      buf_valid       <= {ELEM_NUM{1'b0}};
      buf_count       <= 6'd0;
      open_line       <= 64'd0;
      cmd_valid       <= 1'b0;
      cmd_address     <= 64'd0;
      cmd_data        <= {LINE_BITS{1'b0}};
      cmd_byte_enable <= {CACHELINE_SIZE{1'b0}};
      cmd_elem_count  <= 6'd0;
      flush_done      <= 1'b0;
    end else begin
      state           <= n_state;
      buf_data        <= n_buf_data;
      buf_valid       <= n_buf_valid;
      buf_count       <= n_buf_count;
      open_line       <= n_open_line;
      cmd_valid       <= n_out_valid;
      cmd_address     <= n_out_address;
      cmd_data        <= n_out_data;
      cmd_byte_enable <= n_out_be;
      cmd_elem_count  <= n_out_count;
      flush_done      <= n_flush_done;
    end
  end

endmodule

// File: tb/tb_cu_data_write_packer.sv
// Directed self-checking bench for cu_data_write_packer.
module tb_cu_data_write_packer;

  localparam logic [7:0] EXP_ID = 8'h5A;

  logic          clock = 1'b0;
  logic          reset;
  logic          enabled;
  logic [0:63]   base_address;
  logic          data_in_valid;
  logic          data_in_ready;
  logic [31:0]   data_in_index;
  logic [31:0]   data_in_value;
  logic          flush;
  logic          flush_done;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [0:63]   cmd_address;
  logic [0:1023] cmd_data;
  logic [127:0]  cmd_byte_enable;
  logic [5:0]    cmd_elem_count;
  logic [7:0]    cmd_id;

  always #5 clock = ~clock;

  cu_data_write_packer #(.CMD_ID(EXP_ID)) dut (
    .clock(clock), .reset(reset), .enabled(enabled), .base_address(base_address),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_in_index(data_in_index), .data_in_value(data_in_value),
    .flush(flush), .flush_done(flush_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_address(cmd_address),
    .cmd_data(cmd_data), .cmd_byte_enable(cmd_byte_enable),
    .cmd_elem_count(cmd_elem_count), .cmd_id(cmd_id)
  );

  typedef struct packed {
    logic [63:0]   addr;
    logic [1023:0] data;
    logic [127:0]  be;
    logic [5:0]    cnt;
    logic [7:0]    id;
  } cmd_t;

  cmd_t cmd_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Record every command transfer (inputs only change at the falling edge).
  always begin
    @(negedge clock);
    #2;
    if (cmd_valid && cmd_ready && !reset)
      cmd_q.push_back(cmd_t'({cmd_address, cmd_data, cmd_byte_enable, cmd_elem_count, cmd_id}));
  end

  task automatic check_eq(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] idx, input logic [31:0] val);
    int waited;
    waited = 0;
    data_in_valid = 1'b1;
    data_in_index = idx;
    data_in_value = val;
    #1;
    while (!data_in_ready && waited < 100) begin
      @(negedge clock);
      #1;
      waited++;
    end
    if (!data_in_ready) check_eq("beat_accept_timeout", data_in_ready, 1'b1);
    @(negedge clock);
    data_in_valid = 1'b0;
  endtask

  task automatic pulse_flush(output int lat, output int q_at_done);
    lat = 0;
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    #3;
    while (!flush_done && lat < 60) begin
      @(negedge clock);
      #3;
      lat++;
    end
    check_eq("flush_done_seen", flush_done, 1'b1);
    q_at_done = cmd_q.size();
    @(negedge clock);
    #3;
    check_eq("flush_done_single", flush_done, 1'b0);
  endtask

  task automatic expect_cmd(input string tag, input logic [63:0] addr, input logic [0:1023] data,
                            input logic [127:0] be, input logic [5:0] cnt);
    cmd_t c;
    check_eq({tag, "_present"}, (cmd_q.size() > 0), 1'b1);
    if (cmd_q.size() > 0) begin
      c = cmd_q.pop_front();
      check_eq({tag, "_addr"}, c.addr, addr);
      check_eq({tag, "_data"}, c.data, data);
      check_eq({tag, "_be"},   c.be,   be);
      check_eq({tag, "_cnt"},  c.cnt,  cnt);
      check_eq({tag, "_id"},   c.id,   EXP_ID);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:1023] ed;
    int lat;
    int qd;

    reset = 1'b1; enabled = 1'b0; base_address = 64'h1000;
    data_in_valid = 1'b0; data_in_index = 32'd0; data_in_value = 32'd0;
    flush = 1'b0; cmd_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    // Reset state
    check_eq("rst_cmd_valid", cmd_valid, 1'b0);
    check_eq("rst_flush_done", flush_done, 1'b0);
    check_eq("rst_cmd_address", cmd_address, 64'd0);
    check_eq("rst_cmd_count", cmd_elem_count, 6'd0);
    check_eq("rst_cmd_be", cmd_byte_enable, 128'd0);
    check_eq("rst_cmd_id", cmd_id, EXP_ID);
    check_eq("disabled_not_ready", data_in_ready, 1'b0);
    @(negedge clock);
    enabled = 1'b1;

    // Full sequential line
    ed = {1024{1'b0}};
    for (int i = 0; i < 32; i++) begin
      ed[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      send_beat(32'(i), 32'hA000_0000 + 32'(i));
      if (i == 30) begin
        #1;
        check_eq("full_no_early_cmd", cmd_valid, 1'b0);
        check_eq("full_no_early_q", cmd_q.size(), 0);
      end
    end
    #1;
    check_eq("full_latency", cmd_valid, 1'b1);
    repeat (3) @(negedge clock);
    expect_cmd("full", 64'h1000, ed, {128{1'b1}}, 6'd32);

    // Line crossing
    send_beat(32'd30, 32'h1111_1111);
    send_beat(32'd31, 32'h2222_2222);
    send_beat(32'd32, 32'h3333_3333);
    #1;
    check_eq("cross_latency", cmd_valid, 1'b1);
    pulse_flush(lat, qd);
    check_eq("cross_cmds_before_done", qd, 2);
    ed = {1024{1'b0}};
    ed[30*32 +: 32] = 32'h1111_1111;
    ed[31*32 +: 32] = 32'h2222_2222;
    expect_cmd("cross_a", 64'h1000, ed, 128'hFF << 120, 6'd2);
    ed = {1024{1'b0}};
    ed[0 +: 32] = 32'h3333_3333;
    expect_cmd("cross_b", 64'h1080, ed, 128'hF, 6'd1);

    // Duplicate slot, plus enable low blocking input
    send_beat(32'd5, 32'h3F80_0000);
    send_beat(32'd5, 32'h4000_0000);
    enabled = 1'b0;
    data_in_valid = 1'b1;
    #1;
    check_eq("disabled_ready_low", data_in_ready, 1'b0);
    data_in_valid = 1'b0;
    pulse_flush(lat, qd);
    check_eq("dup_cmds_before_done", qd, 1);
    enabled = 1'b1;
    ed = {1024{1'b0}};
    ed[160 +: 32] = 32'h4000_0000;
    expect_cmd("dup", 64'h1000, ed, 128'hF << 20, 6'd1);

    // Backpressure during a line change
    cmd_ready = 1'b0;
    send_beat(32'd0, 32'hB000_0000);
    send_beat(32'd1, 32'hB000_0001);
    send_beat(32'd40, 32'hB000_0028);
    data_in_valid = 1'b1;
    data_in_index = 32'd41;
    data_in_value = 32'hB000_0029;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("bp_ready_low", data_in_ready, 1'b0);
      check_eq("bp_cmd_valid", cmd_valid, 1'b1);
      check_eq("bp_cmd_addr", cmd_address, 64'h1000);
      check_eq("bp_cmd_count", cmd_elem_count, 6'd2);
      check_eq("bp_cmd_be", cmd_byte_enable, 128'hFF);
      @(negedge clock);
    end
    cmd_ready = 1'b1;
    #1;
    check_eq("bp_ready_rises", data_in_ready, 1'b1);
    @(negedge clock);
    data_in_valid = 1'b0;
    pulse_flush(lat, qd);
    check_eq("bp_cmds_before_done", qd, 2);
    ed = {1024{1'b0}};
    ed[0 +: 32]  = 32'hB000_0000;
    ed[32 +: 32] = 32'hB000_0001;
    expect_cmd("bp_a", 64'h1000, ed, 128'hFF, 6'd2);
    ed = {1024{1'b0}};
    ed[8*32 +: 32] = 32'hB000_0028;
    ed[9*32 +: 32] = 32'hB000_0029;
    expect_cmd("bp_b", 64'h1080, ed, 128'hFF << 32, 6'd2);

    // Unaligned base
    base_address = 64'h1040;
    send_beat(32'd16, 32'hC0DE_0016);
    pulse_flush(lat, qd);
    ed = {1024{1'b0}};
    ed[0 +: 32] = 32'hC0DE_0016;
    expect_cmd("unaligned", 64'h1080, ed, 128'hF, 6'd1);
    base_address = 64'h1000;

    // Empty flush
    pulse_flush(lat, qd);
    check_eq("empty_flush_latency", lat, 0);
    repeat (3) @(negedge clock);
    check_eq("empty_flush_no_cmd", cmd_q.size(), 0);

    // Async reset while holding 7 elements
    for (int i = 0; i < 7; i++) send_beat(32'(i), 32'hD000_0000 + 32'(i));
    reset = 1'b1;
    #1;
    check_eq("amid_rst_valid", cmd_valid, 1'b0);
    check_eq("amid_rst_addr", cmd_address, 64'd0);
    check_eq("amid_rst_count", cmd_elem_count, 6'd0);
    check_eq("amid_rst_data", cmd_data, 1024'd0);
    @(negedge clock);
    reset = 1'b0;
    pulse_flush(lat, qd);
    check_eq("post_rst_flush_latency", lat, 0);
    repeat (5) @(negedge clock);
    check_eq("post_rst_no_cmd", cmd_q.size(), 0);
    check_eq("post_rst_valid", cmd_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cu_data_write_packer.md
Name: cu_data_write_packer

Overview:
- Write-side counterpart of the edge-data read path in the PageRank PULL/Float compute unit.
- Accepts one 32-bit float result per cycle, addressed by vertex index, and coalesces results into a 128-byte cacheline buffer.
- Issues one cacheline write command with per-byte enables toward the AFU command arbiter.
- Sits between the vertex CUs' result stream and the command/write-data buffers; tags every command with the edge-data-write control ID.

Parameters:
- CACHELINE_SIZE, 128, bytes per cacheline.
- DATA_SIZE_WRITE, 4, bytes per element.
- ELEM_NUM, CACHELINE_SIZE/DATA_SIZE_WRITE (32), elements per line.
- CMD_ID, EDGE_DATA_WRITE_CONTROL_ID, command tag driven on cmd_id.
- CMD_ID_BITS, 8, width of cmd_id.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- enabled  in  1  block enable; when low, no input accepted, buffered state held
- base_address  in  64  array base address, big-endian [0:63], stable while enabled
- data_in_valid  in  1  result beat valid
- data_in_ready  out  1  beat accepted when valid && ready
- data_in_index  in  32  vertex index
- data_in_value  in  32  float result
- flush  in  1  single-cycle pulse: emit any partial line
- flush_done  out  1  single-cycle pulse: buffer and output empty after flush
- cmd_valid  out  1  write command valid
- cmd_ready  in  1  arbiter accepts command
- cmd_address  out  64  cacheline-aligned address
- cmd_data  out  1024  line data [0:1023]; element k at bits [32k:32k+31]
- cmd_byte_enable  out  128  bit b set means byte b valid
- cmd_elem_count  out  6  number of distinct valid elements (1..32)
- cmd_id  out  CMD_ID_BITS  equals CMD_ID

Behaviour:
- Reset: all outputs 0 except cmd_id = CMD_ID; buffer empty; state IDLE.
- Address arithmetic: addr = base_address + (index << 2), 64-bit, wrap-around ignored. Line address = addr & {57 ones, 7 zeros}. Slot = addr[57:61], i.e. the 7-bit offset >> 2.
- States:
  - IDLE: buffer empty.
  - FILL: buffer holds elements of open_line.
  - OUT: output register valid, buffer may be filling.
  - FLUSH: flush requested, waiting for drain.
- Output register: single entry. cmd_valid holds with stable fields until cmd_ready. A command transfers on the cycle cmd_valid && cmd_ready.
- data_in_ready = enabled && !(cmd_valid && !cmd_ready) && state != FLUSH.
- Accepted beat, buffer empty: open_line = line address; write slot; count = 1; state FILL.
- Accepted beat, same line, new slot: write slot, count + 1.
- Accepted beat, same line, slot already valid: overwrite data, count unchanged.
- Accepted beat, different line: buffer moves to the output register in the same cycle. The new beat opens a fresh buffer.
- Slot fill reaches 32: line moves to the output register on the next edge, with count 32 and enables all ones.
- Latency: a filling beat produces cmd_valid 1 cycle after acceptance. A mismatch beat produces cmd_valid for the old line 1 cycle after acceptance.
- flush:
  - Non-empty buffer: enter FLUSH, move the buffer to the output register once it is free, then pulse flush_done on the cycle after that command transfers.
  - Buffer and output empty: pulse flush_done the next cycle.
  - Flush arriving the same cycle as an accepted beat: the beat is included in the flushed line.
- cmd_byte_enable: 4 bits set per valid slot; unwritten slot data is 0.
- enabled low: data_in_ready = 0. The output handshake still completes. flush is still honored.
- Reset mid-operation: buffered data discarded, no command issued, all outputs return to reset values immediately.

Test Plan:
- Full sequential line: base 0x1000, indices 0..31, cmd_ready = 1 → one command with cmd_address 0x1000, enables all ones, count 32, cmd_id = CMD_ID.
- Line crossing: indices 30, 31, 32 → first command at 0x1000 with count 2 and enables bytes 120..127; then flush → second command at 0x1080, count 1, enables bytes 0..3, followed by flush_done.
- Duplicate slot: index 5 with value 0x3F800000, then index 5 with value 0x40000000, then flush → count 1, cmd_data bits [160:191] = 0x40000000.
- Backpressure: cmd_ready = 0 for 10 cycles during a line change → data_in_ready low until cmd_ready rises, no beat lost, command fields stable throughout.
- Unaligned base: base 0x1040, index 16 → cmd_address 0x1080, slot 0.
- Empty flush and async reset: flush with no data → flush_done after 1 cycle and no cmd_valid. Reset asserted while holding 7 elements → cmd_valid stays 0 and a later flush produces no command.
